mul_arbiter: RTL and testbench

MUL_ARBITER -- requirements
Module: mul_arbiter

---
 rtl/mul_arbiter.sv | 127 ++++++++++++
 tb/tb_mul_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter sharing one iterative multiplier among NUM_REQ requesters.
// One transaction in flight; the result is held on rsp_valid/rsp_data until the granted requester accepts it.
module mul_arbiter #(
    parameter int WIDTH   = 2,
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*WIDTH-1:0]   req_b,
    output logic [NUM_REQ-1:0]         rsp_valid,
    input  logic [NUM_REQ-1:0]         rsp_ready,
    output logic [2*WIDTH-1:0]         rsp_data,
    output logic                       mul_in_valid,
    output logic [WIDTH-1:0]           mul_a,
    output logic [WIDTH-1:0]           mul_b,
    input  logic [2*WIDTH-1:0]         mul_o,
    input  logic                       mul_out_valid,
    output logic                       fault
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int IW = PW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_t;

    state_t              state, state_nxt;
    logic [PW-1:0]       ptr, grant, win_idx, cand;
    logic [IW-1:0]       idx_sum;
    logic                win_any;
    logic [WIDTH-1:0]    op_a, op_b;
    logic [2*WIDTH-1:0]  result;
    logic [CW-1:0]       cnt;
    logic                fault_q;

    // Scan downwards so the candidate closest to ptr is the last one written.
    always_comb begin
        win_any = 1'b0;
        win_idx = '0;
        idx_sum = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx_sum = {1'b0, ptr} + IW'(i);
            if (idx_sum >= IW'(NUM_REQ))
                idx_sum = idx_sum - IW'(NUM_REQ);
            cand = idx_sum[PW-1:0];
            if (req_valid[cand]) begin
                win_any = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (win_any) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (mul_out_valid || cnt == CW'(TIMEOUT - 1)) state_nxt = DRAIN;
            DRAIN: if (!mul_out_valid) state_nxt = RESP;
            RESP:  if (rsp_ready[grant]) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (rst_n && state == IDLE && win_any)
            req_ready = NUM_REQ'(1) << win_idx;
        if (state == RESP)
            rsp_valid = NUM_REQ'(1) << grant;
    end

    assign mul_in_valid = (state == ISSUE);
    assign mul_a        = op_a;
    assign mul_b        = op_b;
    assign rsp_data     = result;
    assign fault        = fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr     <= '0;
            grant   <= '0;
            op_a    <= '0;
            op_b    <= '0;
            result  <= '0;
            cnt     <= '0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (win_any) begin
                    grant <= win_idx;
                    op_a  <= req_a[win_idx*WIDTH +: WIDTH];
                    op_b  <= req_b[win_idx*WIDTH +: WIDTH];
                    cnt   <= '0;
                end
                WAIT: begin
                    // A real result arriving on the last allowed cycle still wins over the timeout.
                    if (mul_out_valid) begin
                        result <= mul_o;
                    end else if (cnt == CW'(TIMEOUT - 1)) begin
                        result  <= '1;
                        fault_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                RESP: if (rsp_ready[grant]) begin
                    if (grant == PW'(NUM_REQ - 1)) ptr <= '0;
                    else                           ptr <= grant + PW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed + randomized bench for mul_arbiter with a behavioural multiplier and round-robin reference model.
module tb_mul_arbiter;
    localparam int W  = 2;
    localparam int N  = 3;
    localparam int TO = 16;
    localparam int AW = N * W;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [AW-1:0]   req_a = '0, req_b = '0;
    logic [N-1:0]    rsp_valid;
    logic [N-1:0]    rsp_ready = '0;
    logic [2*W-1:0]  rsp_data;
    logic            mul_in_valid;
    logic [W-1:0]    mul_a, mul_b;
    logic [2*W-1:0]  mul_o = '0;
    logic            mul_out_valid = 1'b0;
    logic            fault;

    int  tests = 0;
    int  fails = 0;
    int  m_ptr = 0;
    bit  m_fault = 0;
    bit  mul_hang = 0;
    bit  fix_ops = 0;

    mul_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .mul_in_valid(mul_in_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_o(mul_o), .mul_out_valid(mul_out_valid),
        .fault(fault)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: result after 1..W+2 cycles of WAIT, finish flag held 1 or 2 cycles.
    initial begin
        logic [W-1:0] a, b;
        int lat, hold;
        forever begin
            @(negedge clk);
            if (mul_in_valid === 1'b1 && !mul_hang) begin
                a    = mul_a;
                b    = mul_b;
                lat  = (a == 0 || b == 0) ? 1 : int'($urandom_range(1, W + 2));
                hold = (a == 0 || b == 0) ? 2 : int'($urandom_range(1, 2));
                repeat (lat) @(negedge clk);
                mul_o         = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                mul_out_valid = 1'b1;
                repeat (hold) @(negedge clk);
                mul_out_valid = 1'b0;
                mul_o         = (2*W)'($urandom);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++)
            if (m[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    // One full transaction starting at a negedge in IDLE; ends at a negedge back in IDLE.
    task automatic txn(input logic [N-1:0] vmask, input int bp, input bit hang);
        int g, ia, ib, exp, n, pulses;
        req_valid = vmask;
        mul_hang  = hang;
        if (!fix_ops) begin
            req_a = AW'($urandom);
            req_b = AW'($urandom);
        end
        #1;
        g = winner(vmask, m_ptr);
        if (g < 0) begin
            chk("idle_no_ready", 32'(req_ready), 0);
            @(negedge clk);
            chk("idle_no_issue", 32'(mul_in_valid), 0);
            req_valid = '0;
            return;
        end
        chk("grant_ready", 32'(req_ready), 1 << g);
        ia  = int'((req_a >> (g * W)) & AW'((1 << W) - 1));
        ib  = int'((req_b >> (g * W)) & AW'((1 << W) - 1));
        exp = hang ? (1 << (2 * W)) - 1 : ia * ib;
        @(negedge clk);
        chk("issue_pulse", 32'(mul_in_valid), 1);
        chk("issue_a", 32'(mul_a), ia);
        chk("issue_b", 32'(mul_b), ib);
        chk("busy_ready", 32'(req_ready), 0);
        req_a  = AW'($urandom);
        req_b  = AW'($urandom);
        n      = 0;
        pulses = 0;
        while (rsp_valid === '0 && n < 60) begin
            @(negedge clk);
            n++;
            if (mul_in_valid === 1'b1) pulses++;
        end
        chk("single_issue", pulses, 0);
        if (hang) chk("timeout_latency", n, TO + 2);
        else      chk("latency_bound", 32'(n <= W + 5), 1);
        m_fault = m_fault | hang;
        chk("rsp_valid", 32'(rsp_valid), 1 << g);
        chk("rsp_data", 32'(rsp_data), exp);
        chk("fault", 32'(fault), 32'(m_fault));
        for (int k = 0; k < bp; k++) begin
            rsp_ready = N'($urandom) & ~N'(1 << g);
            @(negedge clk);
            chk("bp_rsp_valid", 32'(rsp_valid), 1 << g);
            chk("bp_rsp_data", 32'(rsp_data), exp);
            chk("bp_req_ready", 32'(req_ready), 0);
            chk("bp_no_issue", 32'(mul_in_valid), 0);
        end
        rsp_ready = N'(1 << g);
        @(negedge clk);
        rsp_ready = '0;
        chk("rsp_retired", 32'(rsp_valid), 0);
        m_ptr     = (g + 1) % N;
        req_valid = '0;
    endtask

    initial begin
        // Reset state, including req_ready gating while requests are present.
        req_valid = '1;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_data", 32'(rsp_data), 0);
        chk("rst_mul_in_valid", 32'(mul_in_valid), 0);
        chk("rst_mul_ab", 32'({mul_a, mul_b}), 0);
        chk("rst_fault", 32'(fault), 0);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // Single request 3*3.
        fix_ops = 1;
        req_a = AW'(3);
        req_b = AW'(3);
        txn(3'b001, 0, 0);
        chk("single_data_nine_ptr", m_ptr, 1);
        fix_ops = 0;

        // Contention between req0 and req1: ptr is 1, so grants go 1,0,1,0.
        for (int k = 0; k < 4; k++) txn(3'b011, 0, 0);

        // Zero operand on req1 with a two-cycle finish flag.
        fix_ops = 1;
        req_a = AW'(0);
        req_b = AW'(2 << W);
        txn(3'b010, 0, 0);
        repeat (3) begin
            @(negedge clk);
            chk("zero_single_rsp", 32'(rsp_valid), 0);
        end
        fix_ops = 0;

        // Response backpressure with all requesters clamouring.
        txn(3'b111, 5, 0);

        // Timeout, then a normal transaction with fault still sticky.
        txn(3'b100, 1, 1);
        txn(3'b001, 0, 0);

        // Requester withdraws before the clock edge: no grant, pointer unchanged.
        req_valid = '1;
        #1;
        chk("drop_ready", 32'(req_ready), 1 << m_ptr);
        req_valid = '0;
        @(negedge clk);
        chk("drop_no_issue", 32'(mul_in_valid), 0);
        txn(3'b111, 0, 0);

        // Randomized traffic.
        for (int k = 0; k < 30; k++)
            txn(N'($urandom), int'($urandom_range(0, 3)), 0);

        // Reset during WAIT, with the pointer away from 0 and fault set.
        txn(3'b001, 0, 0);
        mul_hang  = 1;
        req_valid = '1;
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        req_valid = '1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("mid_rst_rsp_data", 32'(rsp_data), 0);
        chk("mid_rst_mul", 32'({mul_in_valid, mul_a, mul_b}), 0);
        chk("mid_rst_fault", 32'(fault), 0);
        req_valid = '0;
        mul_hang  = 0;
        m_ptr     = 0;
        m_fault   = 0;
        @(negedge clk);
        rst_n = 1'b1;
        txn(3'b111, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("no_stale_rsp", 32'(rsp_valid), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
